// File: rtl/cdc_share_sched_if.sv
// Channel bundle for the shared slow-to-fast crossing scheduler: requester
// handshake on one side, launched word/tag/valid/sequence on the other.
interface cdc_share_sched_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 2
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       ack;
    logic [WIDTH-1:0]         xfer_data;
    logic [TAG_W-1:0]         xfer_tag;
    logic                     xfer_valid;
    logic                     xfer_seq;
    logic                     busy;

    modport master (
        output req, req_data,
        input  ack, xfer_data, xfer_tag, xfer_valid, xfer_seq, busy
    );

    modport slave (
        input  req, req_data,
        output ack, xfer_data, xfer_tag, xfer_valid, xfer_seq, busy
    );
endinterface

// File: rtl/cdc_share_sched.sv
// Round-robin scheduler sharing one crossing channel between NUM_REQ requesters;
// each launched word is held HOLD cycles, followed by one quiet GAP cycle.
module cdc_share_sched #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 2,
    parameter int HOLD    = 2
) (
    input  logic               inclk,
    input  logic               reset,
    cdc_share_sched_if.slave   bus
);

    localparam int CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t             state_q,      state_d;
    logic [TAG_W-1:0]   rr_ptr_q,     rr_ptr_d;
    logic [CNT_W-1:0]   hold_cnt_q,   hold_cnt_d;
    logic [NUM_REQ-1:0] ack_q,        ack_d;
    logic [WIDTH-1:0]   xfer_data_q,  xfer_data_d;
    logic [TAG_W-1:0]   xfer_tag_q,   xfer_tag_d;
    logic               xfer_valid_q, xfer_valid_d;
    logic               xfer_seq_q,   xfer_seq_d;
    logic               busy_q,       busy_d;

    logic               grant_found_s;
    logic [TAG_W-1:0]   grant_idx_s;
    logic [TAG_W-1:0]   cand_idx_s;
    logic [WIDTH-1:0]   grant_data_s;

    // Modulo-NUM_REQ index step so non-power-of-two sizes never reach a dead slot.
    function automatic logic [TAG_W-1:0] wrap_idx(input logic [TAG_W-1:0] base,
                                                  input int               off);
        int sum;
        sum = int'(base) + off;
        return TAG_W'(sum % NUM_REQ);
    endfunction

    // Search downward in offset so the nearest set request above rr_ptr wins.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        cand_idx_s    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand_idx_s    = wrap_idx(rr_ptr_q, i);
            grant_found_s = grant_found_s | bus.req[cand_idx_s];
            grant_idx_s   = bus.req[cand_idx_s] ? cand_idx_s : grant_idx_s;
        end
        grant_data_s = bus.req_data[int'(grant_idx_s) * WIDTH +: WIDTH];
    end

    // Next-state and registered-output logic for the IDLE/HOLD/GAP sequence.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        hold_cnt_d   = hold_cnt_q;
        ack_d        = '0;
        xfer_data_d  = xfer_data_q;
        xfer_tag_d   = xfer_tag_q;
        xfer_valid_d = xfer_valid_q;
        xfer_seq_d   = xfer_seq_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_found_s) begin
                    xfer_data_d             = grant_data_s;
                    xfer_tag_d              = grant_idx_s;
                    xfer_valid_d            = 1'b1;
                    xfer_seq_d              = ~xfer_seq_q;
                    ack_d[grant_idx_s]      = 1'b1;
                    rr_ptr_d                = wrap_idx(grant_idx_s, 1);
                    hold_cnt_d              = HOLD_LOAD;
                    state_d                 = ST_HOLD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q != '0) begin
                    hold_cnt_d = hold_cnt_q - CNT_W'(1);
                end else begin
                    xfer_valid_d = 1'b0;
                    state_d      = ST_GAP;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                xfer_valid_d = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any word in flight.
    always_ff @(posedge inclk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            hold_cnt_q   <= '0;
            ack_q        <= '0;
            xfer_data_q  <= '0;
            xfer_tag_q   <= '0;
            xfer_valid_q <= 1'b0;
            xfer_seq_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            hold_cnt_q   <= hold_cnt_d;
            ack_q        <= ack_d;
            xfer_data_q  <= xfer_data_d;
            xfer_tag_q   <= xfer_tag_d;
            xfer_valid_q <= xfer_valid_d;
            xfer_seq_q   <= xfer_seq_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.ack        = ack_q;
    assign bus.xfer_data  = xfer_data_q;
    assign bus.xfer_tag   = xfer_tag_q;
    assign bus.xfer_valid = xfer_valid_q;
    assign bus.xfer_seq   = xfer_seq_q;
    assign bus.busy       = busy_q;

endmodule
